// File: rtl/color_match_judge.sv
//------------------------------------------------------------------------------
// Module   : color_match_judge
// Brief    : Requests a ball/platform color set, validates it, judges landings.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module color_match_judge #(
   parameter int SCORE_W    = 8,
   parameter int LIVES_INIT = 3,
   parameter int MAX_RETRY  = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   output logic               colors_req,
   input  logic               colors_valid,
   input  logic [11:0]        new_color_plats,
   input  logic [2:0]         new_color_ball,
   input  logic               land_valid,
   input  logic [1:0]         land_plat,
   output logic [2:0]         ball_color,
   output logic [11:0]        plat_colors,
   output logic               armed,
   output logic               hit,
   output logic               miss,
   output logic [SCORE_W-1:0] score,
   output logic [2:0]         lives,
   output logic               game_over,
   output logic               fault
);

   localparam logic [2:0]         c_lives_init = 3'(LIVES_INIT);
   localparam logic [3:0]         c_max_retry  = 4'(MAX_RETRY);
   localparam logic [SCORE_W-1:0] c_score_max  = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_CHECK = 3'd2,
      S_PLAY  = 3'd3,
      S_OVER  = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   state_t             r_state, w_state;
   logic               r_colors_req, w_colors_req;
   logic [2:0]         r_ball, w_ball;
   logic [11:0]        r_plats, w_plats;
   logic               r_armed, w_armed;
   logic               r_hit, w_hit;
   logic               r_miss, w_miss;
   logic [SCORE_W-1:0] r_score, w_score;
   logic [2:0]         r_lives, w_lives;
   logic               r_over, w_over;
   logic               r_fault, w_fault;
   logic [3:0]         r_reject, w_reject;
   logic [3:0]         w_reject_inc;
   logic [2:0]         w_slot [4];
   logic               w_legal;

   for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      assign w_slot[gi] = r_plats[3*gi +: 3];
   end

   // Legal set: nonzero ball, no empty slot, and the ball color is reachable.
   always_comb begin
      logic w_any_match;
      logic w_any_zero;
      w_any_match = 1'b0;
      w_any_zero  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (w_slot[i] == r_ball) w_any_match = 1'b1;
         if (w_slot[i] == 3'd0)   w_any_zero  = 1'b1;
      end
      w_legal = (r_ball != 3'd0) && !w_any_zero && w_any_match;
   end

   assign w_reject_inc = r_reject + 4'd1;

   always_comb begin
      w_state      = r_state;
      w_colors_req = r_colors_req;
      w_ball       = r_ball;
      w_plats      = r_plats;
      w_armed      = r_armed;
      w_hit        = 1'b0;
      w_miss       = 1'b0;
      w_score      = r_score;
      w_lives      = r_lives;
      w_over       = r_over;
      w_fault      = r_fault;
      w_reject     = r_reject;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state      = S_REQ;
               w_colors_req = 1'b1;
            end
         end
         S_REQ: begin
            if (colors_valid) begin
               w_ball       = new_color_ball;
               w_plats      = new_color_plats;
               w_colors_req = 1'b0;
               w_state      = S_CHECK;
            end
         end
         S_CHECK: begin
            if (w_legal) begin
               w_reject = 4'd0;
               w_armed  = 1'b1;
               w_state  = S_PLAY;
            end else begin
               w_reject = w_reject_inc;
               if (w_reject_inc == c_max_retry) begin
                  w_fault = 1'b1;
                  w_state = S_FAULT;
               end else begin
                  w_colors_req = 1'b1;
                  w_state      = S_REQ;
               end
            end
         end
         S_PLAY: begin
            if (land_valid) begin
               w_armed = 1'b0;
               if (w_slot[land_plat] == r_ball) begin
                  w_hit        = 1'b1;
                  w_score      = (r_score == c_score_max) ? r_score : r_score + 1'b1;
                  w_colors_req = 1'b1;
                  w_state      = S_REQ;
               end else begin
                  w_miss  = 1'b1;
                  w_lives = r_lives - 3'd1;
                  if (r_lives == 3'd1) begin
                     w_over  = 1'b1;
                     w_state = S_OVER;
                  end else begin
                     w_colors_req = 1'b1;
                     w_state      = S_REQ;
                  end
               end
            end
         end
         S_OVER: begin
            if (start) begin
               w_score      = '0;
               w_lives      = c_lives_init;
               w_over       = 1'b0;
               w_reject     = 4'd0;
               w_colors_req = 1'b1;
               w_state      = S_REQ;
            end
         end
         default: begin
            w_colors_req = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_colors_req <= 1'b0;
         r_ball       <= 3'd0;
         r_plats      <= 12'd0;
         r_armed      <= 1'b0;
         r_hit        <= 1'b0;
         r_miss       <= 1'b0;
         r_score      <= '0;
         r_lives      <= c_lives_init;
         r_over       <= 1'b0;
         r_fault      <= 1'b0;
         r_reject     <= 4'd0;
      end else begin
         r_state      <= w_state;
         r_colors_req <= w_colors_req;
         r_ball       <= w_ball;
         r_plats      <= w_plats;
         r_armed      <= w_armed;
         r_hit        <= w_hit;
         r_miss       <= w_miss;
         r_score      <= w_score;
         r_lives      <= w_lives;
         r_over       <= w_over;
         r_fault      <= w_fault;
         r_reject     <= w_reject;
      end
   end

   assign colors_req  = r_colors_req;
   assign ball_color  = r_ball;
   assign plat_colors = r_plats;
   assign armed       = r_armed;
   assign hit         = r_hit;
   assign miss        = r_miss;
   assign score       = r_score;
   assign lives       = r_lives;
   assign game_over   = r_over;
   assign fault       = r_fault;

endmodule

`default_nettype wire
